// File: rtl/triangle_list_ctrl.sv
// Triangle list controller: appends loader triangles into an external RAM and
// replays them each frame over valid/ready. Optional frame counter: TRI_FRAME_CNT_EN.
module triangle_list_ctrl #(
  parameter  int WI     = 8,
  parameter  int WF     = 8,
  parameter  int Waddr  = 7,
  parameter  int SIZE   = 100,
  localparam int DATA_W = (WI + WF) * 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              frame_start,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [Waddr:0]    tri_count,
  output logic              ram_r_en,
  output logic              ram_w_en,
  output logic [Waddr-1:0]  ram_r_addr,
  output logic [Waddr-1:0]  ram_w_addr,
  output logic              ram_is_empty,
  output logic              ram_is_full,
  output logic [DATA_W-1:0] ram_wdata,
`ifdef TRI_FRAME_CNT_EN
  output logic [15:0]       frame_cnt,
`endif
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [0:0]     S_IDLE   = 1'b0;
  localparam logic [0:0]     S_STREAM = 1'b1;
  localparam logic [Waddr:0] SIZE_C   = SIZE[Waddr:0];
  localparam logic [Waddr:0] ONE_C    = {{Waddr{1'b0}}, 1'b1};

  logic [0:0]        state;
  logic [Waddr:0]    rd_ptr;
  logic              empty_done;
  logic              rd_vld_p1;
  logic [DATA_W-1:0] buf_data_p2 [2];
  logic              buf_wr_p2;
  logic              buf_rd_p2;
  logic [1:0]        buf_cnt_p2;

  logic       idle;
  logic       streaming;
  logic       start_ok;
  logic       first_rd;
  logic       stream_rd;
  logic       wr_fire;
  logic       pop;
  logic       last_pop;
  logic [1:0] occ_after;

  always_comb begin
    idle      = (state == S_IDLE);
    streaming = (state == S_STREAM);
    // clear outranks frame_start; frame_start outranks a write
    start_ok  = idle & frame_start & ~clear;
    in_ready  = ~Reset & idle & (tri_count < SIZE_C) & ~clear & ~frame_start;
    wr_fire   = in_valid & in_ready;

    out_valid = ~Reset & streaming & (buf_cnt_p2 != 2'd0);
    out_data  = buf_data_p2[buf_rd_p2];
    pop       = out_valid & out_ready;

    // Slots still committed after this cycle's pop; counting the pop lets a
    // 2-entry buffer sustain one triangle per cycle.
    occ_after = buf_cnt_p2 + {1'b0, rd_vld_p1} - {1'b0, pop};
    // Index 0 is fetched in the frame_start cycle itself to save one cycle.
    first_rd  = start_ok & (tri_count != '0);
    stream_rd = streaming & (rd_ptr < tri_count) & (occ_after < 2'd2);
    last_pop  = pop & (rd_ptr == tri_count) & ~rd_vld_p1 & (buf_cnt_p2 == 2'd1);

    ram_r_en     = ~Reset & (first_rd | stream_rd);
    ram_r_addr   = first_rd ? '0 : rd_ptr[Waddr-1:0];
    ram_w_en     = wr_fire;
    ram_w_addr   = tri_count[Waddr-1:0];
    ram_wdata    = in_data;
    ram_is_empty = (tri_count == '0);
    ram_is_full  = (tri_count == SIZE_C);
    frame_busy   = ~Reset & streaming;
    frame_done   = ~Reset & (empty_done | last_pop);
  end

  // Control state: list bookkeeping, read issue and buffer pointers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      tri_count  <= '0;
      rd_ptr     <= '0;
      empty_done <= 1'b0;
      rd_vld_p1  <= 1'b0;
      buf_wr_p2  <= 1'b0;
      buf_rd_p2  <= 1'b0;
      buf_cnt_p2 <= 2'd0;
    end else begin
      empty_done <= start_ok & (tri_count == '0);
      rd_vld_p1  <= ram_r_en;
      if (idle) begin
        if (clear)
          tri_count <= '0;
        else if (wr_fire)
          tri_count <= tri_count + ONE_C;
        if (start_ok) begin
          rd_ptr <= first_rd ? ONE_C : '0;
          if (first_rd)
            state <= S_STREAM;
        end
      end else begin
        if (stream_rd)
          rd_ptr <= rd_ptr + ONE_C;
        if (last_pop)
          state <= S_IDLE;
      end
      if (rd_vld_p1)
        buf_wr_p2 <= ~buf_wr_p2;
      if (pop)
        buf_rd_p2 <= ~buf_rd_p2;
      buf_cnt_p2 <= buf_cnt_p2 + {1'b0, rd_vld_p1} - {1'b0, pop};
    end
  end

  // p1 -> p2: RAM word lands in the output buffer one cycle after issue
  always_ff @(posedge Clk) begin
    if (rd_vld_p1)
      buf_data_p2[buf_wr_p2] <= ram_rdata;
  end

`ifdef TRI_FRAME_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      frame_cnt <= 16'd0;
    else if (frame_done)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_triangle_list_ctrl.sv
// Directed bench for triangle_list_ctrl with a RAM model and an output scoreboard.
module tb_triangle_list_ctrl;
  localparam int WI     = 8;
  localparam int WF     = 8;
  localparam int Waddr  = 7;
  localparam int SIZE   = 100;
  localparam int DATA_W = (WI + WF) * 9;

  logic              Clk = 1'b0;
  logic              Reset, clear, in_valid, frame_start, out_ready;
  logic              in_ready, frame_busy, frame_done, out_valid;
  logic [DATA_W-1:0] in_data, out_data, ram_wdata, ram_rdata;
  logic [Waddr:0]    tri_count;
  logic              ram_r_en, ram_w_en, ram_is_empty, ram_is_full;
  logic [Waddr-1:0]  ram_r_addr, ram_w_addr;
`ifdef TRI_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  always #5 Clk = ~Clk;

  triangle_list_ctrl #(.WI(WI), .WF(WF), .Waddr(Waddr), .SIZE(SIZE)) dut (
    .Clk(Clk), .Reset(Reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .frame_start(frame_start),
    .frame_busy(frame_busy), .frame_done(frame_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .tri_count(tri_count),
    .ram_r_en(ram_r_en), .ram_w_en(ram_w_en), .ram_r_addr(ram_r_addr),
    .ram_w_addr(ram_w_addr), .ram_is_empty(ram_is_empty),
    .ram_is_full(ram_is_full), .ram_wdata(ram_wdata),
`ifdef TRI_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .ram_rdata(ram_rdata)
  );

  logic [DATA_W-1:0] ram_mem [2**Waddr];
  always @(posedge Clk) begin
    if (ram_w_en) ram_mem[ram_w_addr] <= ram_wdata;
    if (ram_r_en) ram_rdata <= ram_mem[ram_r_addr];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accept_cnt = 0, done_cnt = 0;
  int first_valid_cyc = -1, last_acc_cyc = -1, done_cyc = -1;
  int issued = 0, accepted = 0;
  bit expect_empty_done = 1'b0;
  bit stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_q[$];
  int next_id = 1;

  always @(posedge Clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, read outstanding bound
  always @(negedge Clk) begin
    logic [DATA_W-1:0] exp_d;
    logic pop;
    if (Reset) begin
      issued = 0; accepted = 0; stall_prev = 1'b0;
    end else begin
      pop = out_valid & out_ready;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        total++;
        assert (out_data === stall_data) else begin
          bad++;
          $error("FAIL stall_data: observed=%0h expected=%0h", out_data, stall_data);
        end
      end
      stall_prev = out_valid & ~out_ready;
      stall_data = out_data;
      if (ram_r_en) issued++;
      if (pop) begin
        accepted++; accept_cnt++; last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_d = exp_q.pop_front();
          total++;
          assert (out_data === exp_d) else begin
            bad++;
            $error("FAIL out_data: observed=%0h expected=%0h", out_data, exp_d);
          end
        end
      end
      if (ram_r_en) check("outstanding_le2", (issued - accepted) <= 2, 1);
      if (frame_done) begin
        done_cnt++; done_cyc = cyc;
        check("done_when_due", (pop && exp_q.size() == 0) || expect_empty_done, 1);
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  function automatic logic [DATA_W-1:0] mk(input int id);
    return {$urandom, $urandom, $urandom, $urandom, 16'(id)};
  endfunction

  task automatic load(input int n);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = mk(next_id); next_id++;
      in_valid = 1'b1; in_data = d;
      @(negedge Clk);
      check("load_ready", in_ready, 1);
      if (in_ready) model_q.push_back(d);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    model_q.delete();
  endtask

  function automatic logic pat(input int mode, input int k);
    logic [5:0] p;
    p = 6'b101001;
    if (mode == 0) return 1'b1;
    return p[k % 6];
  endfunction

  int start_cyc;
  task automatic run_frame(input int mode, input int clear_at, input int budget);
    int k, d0;
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    d0 = done_cnt; first_valid_cyc = -1;
    expect_empty_done = (model_q.size() == 0);
    frame_start = 1'b1; out_ready = pat(mode, 0); start_cyc = cyc;
    tick();
    frame_start = 1'b0;
    k = 1;
    while (done_cnt == d0 && k < budget) begin
      out_ready = pat(mode, k); clear = (k == clear_at);
      tick(); k++;
    end
    clear = 1'b0; out_ready = 1'b0; expect_empty_done = 1'b0;
    check("frame_done_once", done_cnt - d0, 1);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int a0, d0, k;
`ifdef TRI_FRAME_CNT_EN
    logic [15:0] fc0;
`endif
    Reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    frame_start = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b1;
    @(negedge Clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_w_en", ram_w_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    tick();
    in_valid = 1'b0; Reset = 1'b0;
    @(negedge Clk);
    check("rst_count", tri_count, 0);
    check("rst_empty", ram_is_empty, 1);
    check("rst_busy", frame_busy, 0);
`ifdef TRI_FRAME_CNT_EN
    check("rst_frame_cnt", frame_cnt, 0);
`endif
    tick();

    // Three triangles, full-rate stream
    load(3);
    @(negedge Clk);
    check("t3_count", tri_count, 3);
    tick();
    a0 = accept_cnt;
    run_frame(0, -1, 40);
    check("t3_latency", first_valid_cyc - start_cyc, 2);
    check("t3_accepts", accept_cnt - a0, 3);
    check("t3_done_on_last", done_cyc, last_acc_cyc);
    @(negedge Clk);
    check("t3_count_kept", tri_count, 3);
    check("t3_idle_valid", out_valid, 0);
    check("t3_idle_busy", frame_busy, 0);
    tick();

    // clear + frame_start together
    do_clear();
    load(4);
    d0 = done_cnt;
    clear = 1'b1; frame_start = 1'b1;
    tick();
    clear = 1'b0; frame_start = 1'b0;
    model_q.delete();
    @(negedge Clk);
    check("cf_count", tri_count, 0);
    check("cf_busy", frame_busy, 0);
    tick();
    @(negedge Clk);
    check("cf_no_done", done_cnt - d0, 0);
    check("cf_busy2", frame_busy, 0);
    tick();

    // Empty-list frame
`ifdef TRI_FRAME_CNT_EN
    fc0 = frame_cnt;
`endif
    a0 = accept_cnt;
    run_frame(0, -1, 10);
    check("empty_done_lat", done_cyc - start_cyc, 1);
    check("empty_no_valid", first_valid_cyc, -1);
    check("empty_no_accept", accept_cnt - a0, 0);
`ifdef TRI_FRAME_CNT_EN
    check("empty_frame_cnt", frame_cnt, 32'(fc0 + 16'd1));
`endif

    // Five triangles under toggling backpressure, clear ignored mid-stream
    load(5);
    a0 = accept_cnt;
    run_frame(1, 3, 80);
    check("bp_accepts", accept_cnt - a0, 5);
    @(negedge Clk);
    check("bp_count_kept", tri_count, 5);
    tick();

    // Reset mid-stream after two outputs
    do_clear();
    load(4);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    a0 = accept_cnt;
    frame_start = 1'b1; out_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    k = 0;
    while (accept_cnt - a0 < 2 && k < 20) begin tick(); k++; end
    check("mid_two_out", accept_cnt - a0, 2);
    d0 = done_cnt;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_q.delete(); model_q.delete();
    @(negedge Clk);
    check("mid_valid", out_valid, 0);
    check("mid_busy", frame_busy, 0);
    check("mid_count", tri_count, 0);
    tick(); tick();
    check("mid_no_done", done_cnt - d0, 0);
    out_ready = 1'b0;

    // Fill to SIZE, offer one more, then replay all
    load(SIZE);
    in_valid = 1'b1; in_data = mk(999);
    @(negedge Clk);
    check("full_ready", in_ready, 0);
    check("full_flag", ram_is_full, 1);
    check("full_count", tri_count, SIZE);
    tick(); tick();
    check("full_count_held", tri_count, SIZE);
    in_valid = 1'b0;
    a0 = accept_cnt;
    run_frame(0, -1, 300);
    check("full_accepts", accept_cnt - a0, SIZE);
    check("full_rate", last_acc_cyc - first_valid_cyc, SIZE - 1);
    check("full_latency", first_valid_cyc - start_cyc, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/triangle_list_ctrl.md
Name: triangle_list_ctrl

Overview:
Controller that owns one triangle list RAM (1-cycle registered read, gated by is_empty/is_full) and sequences it between two phases.
- Load phase: the scene loader appends packed triangles.
- Stream phase: on frame_start, every stored triangle is replayed in write order to the transform/raster pipeline over a valid/ready handshake with backpressure.
- Sits between the scene loader and the vertex transform stage; the loader writes once, and the list is replayed each frame.

Parameters:
WI, 8, integer bits per coordinate
WF, 8, fraction bits per coordinate
Waddr, 7, RAM address width
SIZE, 100, max triangles stored (SIZE <= 2**Waddr)

Ports:
Clk  in  1  clock
Reset  in  1  synchronous active-high reset
clear  in  1  one-cycle pulse: empty the list (honoured in IDLE only)
in_valid  in  1  loader offers a triangle
in_ready  out  1  triangle accepted this cycle when in_valid & in_ready
in_data  in  (WI+WF)*9  packed triangle, 3 vertices x (x,y,z)
frame_start  in  1  one-cycle pulse: replay list (honoured in IDLE only)
frame_busy  out  1  high while in STREAM
frame_done  out  1  one-cycle pulse when the last triangle has been accepted downstream
out_valid  out  1  out_data holds a triangle
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  (WI+WF)*9  triangle to pipeline
tri_count  out  Waddr+1  triangles stored
ram_r_en, ram_w_en  out  1  RAM strobes
ram_r_addr, ram_w_addr  out  Waddr  RAM addresses
ram_is_empty  out  1  (tri_count == 0)
ram_is_full  out  1  (tri_count == SIZE)
ram_wdata  out  (WI+WF)*9  = in_data
ram_rdata  in  (WI+WF)*9  RAM data_out, valid 1 cycle after ram_r_en

Behaviour:
- Reset (synchronous, highest priority): state IDLE, tri_count=0, read pointer=0, output buffer empty, in-flight flag=0. Outputs in_ready=0 for that cycle, out_valid=0, frame_busy=0, frame_done=0, ram_r_en=0, ram_w_en=0.
- Reset mid-STREAM aborts with no frame_done; list contents are lost logically (count=0).
- States:
  - IDLE: in_ready = (tri_count < SIZE) & ~clear.
  - IDLE accept: ram_w_en=1, ram_w_addr=tri_count[Waddr-1:0]; tri_count+1 next cycle.
  - IDLE clear: tri_count<=0; the write is blocked that cycle.
  - IDLE frame_start (with clear=0, no write accepted the same cycle): read pointer<=0. If tri_count==0, assert frame_done the next cycle and stay IDLE. Otherwise go to STREAM.
  - IDLE, frame_start together with an accepted write: frame_start wins, in_ready forced 0.
  - STREAM: in_ready=0; clear and frame_start are ignored; frame_busy=1.
- STREAM read issue: ram_r_en=1 with ram_r_addr=read pointer when read pointer < tri_count and (buffer occupancy + in-flight) < 2. Read pointer increments on issue.
- Returned word: captured into a 2-entry FIFO the cycle after issue; out_data/out_valid are driven from the FIFO head.
- Throughput: with out_ready held high, sustain 1 triangle/cycle after 2 cycles of initial latency (frame_start to first out_valid = 2 cycles).
- Backpressure: out_valid stays asserted and out_data is stable until accepted; no triangle is lost or duplicated under any out_ready pattern.
- Completion: when the final triangle (index tri_count-1) is accepted, frame_done pulses that same cycle and the state returns to IDLE the next cycle. out_valid=0 in IDLE.
- Order: triangles leave in write order 0..tri_count-1. The list persists across frames until clear or Reset.
- Full: at tri_count==SIZE, in_ready=0 and ram_is_full=1; extra in_valid is held off, not dropped.

Optional Feature:
TRI_FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0], reset to 0. It increments by 1 on each frame_done, including empty-list frames, and wraps 0xFFFF->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Load 3 triangles (0x..01, 0x..02, 0x..03), frame_start, out_ready=1 -> out_valid from cycle +2 for 3 cycles, data 01,02,03, frame_done on the 3rd acceptance, tri_count=3.
- Load SIZE=100 triangles, offer a 101st -> in_ready=0, ram_is_full=1, tri_count=100; a stream then returns exactly 100 in order.
- Stream 5 triangles with out_ready toggling 1,0,0,1,0,1... -> out_data stable while stalled, exactly 5 acceptances in order, never more than 2 reads outstanding.
- tri_count=0, frame_start -> frame_done one cycle later, out_valid never asserted; with TRI_FRAME_CNT_EN, frame_cnt goes 0->1.
- Reset asserted mid-STREAM after 2 of 4 outputs -> next cycle out_valid=0, frame_busy=0, tri_count=0, no frame_done.
- clear and frame_start in the same IDLE cycle with tri_count=4 -> tri_count=0, no STREAM entry, no frame_done; clear during STREAM is ignored.
